// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS slice: memory sequencer states,
// opcodes shared with the control unit, and default widths.
package mips_pkg;

  localparam int unsigned AW_DEF      = 32;
  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_stall_ctrl.sv
// Memory-access sequencer: turns control-unit memory strobes into a req/ack
// transaction, owns IR/MDR, and stalls the FSM via run. Optional MEM_TIMEOUT_EN.
module mem_stall_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_en,
  input  logic          cu_mem_rd,
  input  logic          cu_mem_wr,
  input  logic          cu_irwrite,
  input  logic          cu_iord,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] alu_out,
  input  logic [DW-1:0] wdata,
  output logic          run,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] mdr,
  output logic          busy,
  output logic          bus_err
);

  if (TIMEOUT == 0) begin : g_timeout_check
    $error("mem_stall_ctrl: TIMEOUT must be at least 1");
  end

  mem_state_t    state, state_n;
  logic          req_n, we_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wd_n, ir_n, mdr_n;
  logic          access;

  assign access = cu_mem_rd | cu_mem_wr;
  assign busy   = (state == WAIT) || (state == DONE);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_q, err_n;
  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      mdr       <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wd_n;
      ir        <= ir_n;
      mdr       <= mdr_n;
`ifdef MEM_TIMEOUT_EN
      cnt       <= cnt_n;
      err_q     <= err_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    req_n   = mem_req;
    we_n    = mem_we;
    addr_n  = mem_addr;
    wd_n    = mem_wdata;
    ir_n    = ir;
    mdr_n   = mdr;
    run     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_n   = cnt;
    err_n   = err_q;
`endif
    case (state)
      IDLE: begin
        if (!access) begin
          run = run_en;
        end else if (run_en) begin
          req_n   = 1'b1;
          we_n    = cu_mem_wr;
          addr_n  = cu_iord ? alu_out : pc;
          wd_n    = wdata;
          state_n = WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      WAIT: begin
        if (mem_ack) begin
          req_n   = 1'b0;
          state_n = DONE;
          // The registered write flag decides capture, so rd&wr never loads data.
          if (!mem_we) begin
            if (cu_irwrite) ir_n  = mem_rdata;
            else            mdr_n = mem_rdata;
          end
`ifdef MEM_TIMEOUT_EN
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = ERR;
        end else begin
          cnt_n = cnt + 1'b1;
`endif
        end
      end
      DONE: begin
        run = run_en;
        if (run_en) state_n = IDLE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: table of memory transactions plus
// hand sequences for stall, release, reset and timeout corners.
module tb_mem_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst, run_en, cu_mem_rd, cu_mem_wr, cu_irwrite, cu_iord;
  logic [31:0] pc, alu_out, wdata, mem_rdata;
  logic        mem_ack;
  logic        run, mem_req, mem_we, busy, bus_err;
  logic [31:0] mem_addr, mem_wdata, ir, mdr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rd, wr, irw, iord;
    logic [31:0] pc, alu, wdata, rdata;
    int unsigned lat;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_ir, exp_mdr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  vec_t vecs[6];
  req_t sb[$];
  logic [31:0] prev_ir, prev_mdr;

  mem_stall_ctrl #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .run_en(run_en),
    .cu_mem_rd(cu_mem_rd), .cu_mem_wr(cu_mem_wr), .cu_irwrite(cu_irwrite), .cu_iord(cu_iord),
    .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .run(run), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .mdr(mdr), .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_access(input logic rd, input logic wr, input logic irw, input logic iord,
                            input logic [31:0] p, input logic [31:0] a, input logic [31:0] wd);
    cu_mem_rd = rd; cu_mem_wr = wr; cu_irwrite = irw; cu_iord = iord;
    pc = p; alu_out = a; wdata = wd;
    #1;
  endtask

  task automatic push_req(input logic [31:0] a, input logic we, input logic [31:0] wd);
    req_t r;
    r.addr = a; r.we = we; r.wdata = wd;
    sb.push_back(r);
  endtask

  // First cycle of a request: compare the bus against the oldest expected request.
  task automatic check_issue(input string tag);
    req_t r;
    chk({tag, "_req"}, mem_req, 1'b1);
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_sb: got no expected entry, required one queued", tag);
    end else begin
      r = sb.pop_front();
      chk({tag, "_addr"},  mem_addr,  r.addr);
      chk({tag, "_we"},    mem_we,    r.we);
      chk({tag, "_wdata"}, mem_wdata, r.wdata);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    run_en = 1'b1;
    set_access(v.rd, v.wr, v.irw, v.iord, v.pc, v.alu, v.wdata);
    chk({t, "_c0_run"},  run,  1'b0);
    chk({t, "_c0_busy"}, busy, 1'b0);
    push_req(v.exp_addr, v.exp_we, v.wdata);
    tick();
    check_issue(t);
    chk({t, "_c1_run"}, run, 1'b0);
    for (int i = 0; i < int'(v.lat); i++) begin
      tick();
      chk({t, "_w_req"},   mem_req,   1'b1);
      chk({t, "_w_run"},   run,       1'b0);
      chk({t, "_w_addr"},  mem_addr,  v.exp_addr);
      chk({t, "_w_wdata"}, mem_wdata, v.wdata);
      chk({t, "_w_ir"},    ir,        prev_ir);
      chk({t, "_w_mdr"},   mdr,       prev_mdr);
    end
    mem_ack = 1'b1; mem_rdata = v.rdata;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    chk({t, "_d_run"},  run,     1'b1);
    chk({t, "_d_req"},  mem_req, 1'b0);
    chk({t, "_d_busy"}, busy,    1'b1);
    chk({t, "_d_ir"},   ir,      v.exp_ir);
    chk({t, "_d_mdr"},  mdr,     v.exp_mdr);
    tick();
    set_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk({t, "_i_busy"}, busy,    1'b0);
    chk({t, "_i_run"},  run,     1'b1);
    chk({t, "_i_req"},  mem_req, 1'b0);
    prev_ir = v.exp_ir; prev_mdr = v.exp_mdr;
  endtask

  initial begin
    //            rd    wr    irw   iord  pc     alu    wdata         rdata         lat addr   we    exp_ir        exp_mdr
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h99, 32'h0000AAAA, 32'h8C220004, 0, 32'h10, 1'b0, 32'h8C220004, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h14, 32'h40, 32'h0,        32'hDEADBEEF, 5, 32'h40, 1'b0, 32'h8C220004, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h18, 32'h44, 32'h12345678, 32'hFFFFFFFF, 3, 32'h44, 1'b1, 32'h8C220004, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h50, 32'h0BADF00D, 32'h55555555, 1, 32'h20, 1'b1, 32'h8C220004, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h24, 32'h54, 32'h0,        32'h01234567, 2, 32'h24, 1'b0, 32'h01234567, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h28, 32'h80, 32'h0,        32'hCAFEF00D, 0, 32'h80, 1'b0, 32'h01234567, 32'hCAFEF00D};

    rst = 1'b1; run_en = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    set_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    prev_ir = '0; prev_mdr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_run", run, 1'b0);   chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0); chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ir", ir, 32'h0);    chk("rst_mdr", mdr, 32'h0);
    chk("rst_busy", busy, 1'b0); chk("rst_buserr", bus_err, 1'b0);

    // Access pending but run_en low: nothing is issued.
    set_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h70, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req", mem_req, 1'b0); chk("hold_run", run, 1'b0); chk("hold_busy", busy, 1'b0);
    end
    set_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    run_en = 1'b1; #1; chk("idle_run_hi", run, 1'b1);
    run_en = 1'b0; #1; chk("idle_run_lo", run, 1'b0);

    // Stray ack in IDLE is ignored.
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    tick();
    mem_ack = 1'b0;
    chk("stray_ir", ir, 32'h0); chk("stray_mdr", mdr, 32'h0);
    chk("stray_req", mem_req, 1'b0); chk("stray_busy", busy, 1'b0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // run_en dropped in WAIT, release pulse, then back-to-back load.
    run_en = 1'b1;
    set_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0);
    push_req(32'h30, 1'b0, 32'h0);
    tick();
    check_issue("b2b_f");
    run_en = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    tick();
    mem_ack = 1'b0;
    chk("hold_done_run", run, 1'b0); chk("hold_done_busy", busy, 1'b1);
    chk("hold_done_ir", ir, 32'h11112222);
    tick();
    chk("hold_done_run2", run, 1'b0); chk("hold_done_busy2", busy, 1'b1);
    chk("hold_done_req", mem_req, 1'b0);
    run_en = 1'b1; #1;
    chk("release_run", run, 1'b1);
    @(posedge clk); @(negedge clk);
    set_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h34, 32'h48, 32'h0);
    chk("b2b_idle_run", run, 1'b0); chk("b2b_idle_busy", busy, 1'b0);
    push_req(32'h48, 1'b0, 32'h0);
    tick();
    check_issue("b2b_l");
    mem_ack = 1'b1; mem_rdata = 32'h33334444;
    tick();
    mem_ack = 1'b0;
    chk("b2b_run", run, 1'b1); chk("b2b_mdr", mdr, 32'h33334444); chk("b2b_ir", ir, 32'h11112222);
    tick();
    set_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("b2b_end_busy", busy, 1'b0);

    // Reset in the second WAIT cycle abandons the request.
    set_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h60, 32'h0);
    push_req(32'h60, 1'b0, 32'h0);
    tick();
    check_issue("rstw");
    tick();
    rst = 1'b1;
    tick();
    chk("rstw_req", mem_req, 1'b0); chk("rstw_busy", busy, 1'b0);
    chk("rstw_ir", ir, 32'h0);      chk("rstw_mdr", mdr, 32'h0);
    chk("rstw_addr", mem_addr, 32'h0);
    set_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();

`ifdef MEM_TIMEOUT_EN
    set_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h90, 32'h0, 32'h0);
    push_req(32'h90, 1'b0, 32'h0);
    tick();
    check_issue("to");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_err", bus_err, 1'b0); chk("to_wait_req", mem_req, 1'b1);
    end
    tick();
    chk("to_err", bus_err, 1'b1); chk("to_req", mem_req, 1'b0);
    chk("to_run", run, 1'b0);     chk("to_busy", busy, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("to_stuck_err", bus_err, 1'b1); chk("to_stuck_run", run, 1'b0);
    chk("to_stuck_ir", ir, 32'h0);
    set_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("to_clr_err", bus_err, 1'b0); chk("to_clr_run", run, 1'b1);
`else
    set_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h90, 32'h0, 32'h0);
    push_req(32'h90, 1'b0, 32'h0);
    tick();
    check_issue("long");
    repeat (300) @(posedge clk);
    @(negedge clk); #1;
    chk("long_req", mem_req, 1'b1); chk("long_err", bus_err, 1'b0); chk("long_run", run, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    tick();
    mem_ack = 1'b0;
    chk("long_ir", ir, 32'h77777777); chk("long_run_done", run, 1'b1);
    tick();
    set_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
